// File: rtl/uart_word_rx.sv
// UART receiver (8N1, LSB first) that packs four bytes little-endian into a word
// and queues words in a 4-deep FIFO, read by a one-word-per-request handshake.
module uart_word_rx #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rxd,
   input  logic        readflag,
   output logic [31:0] recvdata,
   output logic        recv_valid,
   output logic [2:0]  word_count,
   output logic        overflow,
   output logic        framing_err
);

   // state | meaning
   // IDLE  | line idle, waiting for a falling edge on the synchronized line
   // START | half a bit period in, confirm the start bit is still low
   // DATA  | sample 8 data bits, one per bit period, LSB first
   // STOP  | sample the stop bit; high accepts the byte, low is a framing error
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

   state_t      state, state_nxt;
   logic        rxd_meta, rxd_sync;
   logic [15:0] timer;
   logic [2:0]  bit_idx;
   logic [7:0]  shift_reg;
   logic [1:0]  byte_cnt;
   logic [23:0] word_buf;
   logic        timer_clr, bit_sample, byte_ok, frame_bad;

   logic [31:0] fifo_mem [4];
   logic [1:0]  wr_ptr, rd_ptr;
   logic [2:0]  count;
   logic        armed;
   logic        word_done, full, push, pop;
   logic [31:0] word_in;

   always_ff @(posedge clk) begin
      if (reset) begin
         rxd_meta <= 1'b1;
         rxd_sync <= 1'b1;
      end else begin
         rxd_meta <= rxd;
         rxd_sync <= rxd_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      timer_clr  = 1'b0;
      bit_sample = 1'b0;
      byte_ok    = 1'b0;
      frame_bad  = 1'b0;
      case (state)
         IDLE: begin
            timer_clr = 1'b1;
            if (!rxd_sync) state_nxt = START;
         end
         START: begin
            if (timer == HALF_LAST) begin
               timer_clr = 1'b1;
               state_nxt = rxd_sync ? IDLE : DATA;
            end
         end
         DATA: begin
            if (timer == BIT_LAST) begin
               timer_clr  = 1'b1;
               bit_sample = 1'b1;
               if (bit_idx == 3'd7) state_nxt = STOP;
            end
         end
         STOP: begin
            if (timer == BIT_LAST) begin
               timer_clr = 1'b1;
               state_nxt = IDLE;
               if (rxd_sync) byte_ok   = 1'b1;
               else          frame_bad = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         timer       <= '0;
         bit_idx     <= '0;
         shift_reg   <= '0;
         byte_cnt    <= '0;
         word_buf    <= '0;
         framing_err <= 1'b0;
      end else begin
         timer       <= timer_clr ? 16'd0 : timer + 16'd1;
         framing_err <= frame_bad;
         if (bit_sample) begin
            shift_reg <= {rxd_sync, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
         end
         // The fourth byte goes straight into the pushed word, not word_buf.
         if (byte_ok) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
               2'd0:    word_buf[7:0]   <= shift_reg;
               2'd1:    word_buf[15:8]  <= shift_reg;
               2'd2:    word_buf[23:16] <= shift_reg;
               default: ;
            endcase
         end
      end
   end

   assign word_done = byte_ok && (byte_cnt == 2'd3);
   assign word_in   = {shift_reg, word_buf};
   assign full      = (count == 3'd4);
   assign pop       = readflag && armed && (count != 3'd0);
   assign push      = word_done && (!full || pop);

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= word_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         armed      <= 1'b1;
         recvdata   <= '0;
         recv_valid <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         recv_valid <= pop;
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop) begin
            recvdata <= fifo_mem[rd_ptr];
            rd_ptr   <= rd_ptr + 2'd1;
         end
         case ({push, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
         if (word_done && full && !pop) overflow <= 1'b1;
         if (!readflag) armed <= 1'b1;
         else if (pop)  armed <= 1'b0;
      end
   end

   assign word_count = count;

endmodule
